// File: rtl/axis_video_frame_sync_if.sv
// AXI4-Stream bundle for the 2-pixel-per-clock video path (48-bit data, 6-bit keep).
interface axis_video_frame_sync_if;
    logic [47:0] tdata;
    logic [5:0]  tkeep;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, tkeep, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/axis_video_frame_sync.sv
// Video frame synchroniser: locks onto SOF, checks line lengths and frame height
// against the configured geometry, forwards only well-formed beats through a
// 2-entry skid buffer and regenerates tuser/tlast from its own counters.
module axis_video_frame_sync (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           enable,
    input  logic [15:0]                    cfg_transfers_in_line,
    input  logic [15:0]                    cfg_lines_in_frame,
    input  logic                           clear_status,
    axis_video_frame_sync_if.slave         s_axis,
    axis_video_frame_sync_if.master        m_axis,
    output logic [31:0]                    status_frames_passed,
    output logic [31:0]                    status_frames_dropped,
    output logic [2:0]                     status_err
);
    localparam int DATA_W  = 48;
    localparam int KEEP_W  = 6;
    localparam int ENTRY_W = DATA_W + KEEP_W + 2;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PASS     = 2'd1,
        DROP     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] col_q, col_d, row_q, row_d;
    logic [15:0] len_q, len_d, lines_q, lines_d;

    logic [ENTRY_W-1:0] mem_q [2];
    logic               rd_q, wr_q;
    logic [1:0]         count_q, count_d;
    logic               tready_q;

    logic [31:0] passed_q, dropped_q;
    logic [2:0]  err_q;

    logic        accept, pop, sof_ok, relock_err, lock, active;
    logic        c_last, r_last, early, late, fwd;
    logic [15:0] len_e, lines_e, col_e, row_e;
    logic        pass_inc, beat_user, beat_last;
    logic [1:0]  drop_inc;
    logic [2:0]  err_set;

    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + {31'd0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Beat classification. A locking beat is evaluated against the fresh
    // configuration at position (0,0); otherwise the latched geometry is used.
    assign accept     = s_axis.tvalid & tready_q;
    assign pop        = m_axis.tvalid & m_axis.tready;
    assign sof_ok     = s_axis.tuser & enable &
                        (cfg_transfers_in_line != 16'd0) & (cfg_lines_in_frame != 16'd0);
    assign relock_err = accept & (state_q == PASS) & s_axis.tuser &
                        ((col_q != 16'd0) | (row_q != 16'd0));
    assign lock       = accept & sof_ok & ((state_q != PASS) | relock_err);
    assign active     = lock | (accept & (state_q == PASS) & ~relock_err);
    assign len_e      = lock ? cfg_transfers_in_line : len_q;
    assign lines_e    = lock ? cfg_lines_in_frame    : lines_q;
    assign col_e      = lock ? 16'd0 : col_q;
    assign row_e      = lock ? 16'd0 : row_q;
    assign c_last     = (col_e == len_e - 16'd1);
    assign r_last     = (row_e == lines_e - 16'd1);
    assign early      = active & s_axis.tlast & ~c_last;
    assign late       = active & ~s_axis.tlast & c_last;
    assign fwd        = active & ~early & ~late;

    // State and position registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= WAIT_SOF;
            col_q   <= 16'd0;
            row_q   <= 16'd0;
            len_q   <= 16'd0;
            lines_q <= 16'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            len_q   <= len_d;
            lines_q <= lines_d;
        end
    end

    // Next state: lock, abort on a framing error, or advance the column/row.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        len_d   = len_q;
        lines_d = lines_q;
        if (lock) begin
            len_d   = cfg_transfers_in_line;
            lines_d = cfg_lines_in_frame;
        end
        if (relock_err && !lock) begin
            state_d = WAIT_SOF;
            col_d   = 16'd0;
            row_d   = 16'd0;
        end else if (early || late) begin
            state_d = DROP;
            col_d   = 16'd0;
            row_d   = 16'd0;
        end else if (fwd) begin
            if (c_last && r_last) begin
                state_d = WAIT_SOF;
                col_d   = 16'd0;
                row_d   = 16'd0;
            end else if (c_last) begin
                state_d = PASS;
                col_d   = 16'd0;
                row_d   = row_e + 16'd1;
            end else begin
                state_d = PASS;
                col_d   = col_e + 16'd1;
                row_d   = row_e;
            end
        end
    end

    // Outputs of the FSM: regenerated sideband and status events.
    always_comb begin
        beat_user = (col_e == 16'd0) && (row_e == 16'd0);
        beat_last = c_last;
        pass_inc  = fwd & c_last & r_last;
        drop_inc  = {1'b0, relock_err} + {1'b0, early | late};
        err_set   = {relock_err, late, early};
    end

    // Buffer occupancy after this cycle's push/pop.
    always_comb begin
        count_d = count_q + {1'b0, fwd} - {1'b0, pop};
    end

    // Two-entry skid buffer; tready is registered from the next occupancy.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            count_q  <= 2'd0;
            tready_q <= 1'b0;
        end else begin
            if (fwd) begin
                mem_q[wr_q] <= {beat_user, beat_last, s_axis.tkeep, s_axis.tdata};
            end
            wr_q     <= wr_q ^ fwd;
            rd_q     <= rd_q ^ pop;
            count_q  <= count_d;
            tready_q <= (count_d < 2'd2);
        end
    end

    assign s_axis.tready = tready_q;
    assign m_axis.tvalid = (count_q != 2'd0);
    assign m_axis.tuser  = mem_q[rd_q][ENTRY_W-1];
    assign m_axis.tlast  = mem_q[rd_q][ENTRY_W-2];
    assign m_axis.tkeep  = mem_q[rd_q][DATA_W +: KEEP_W];
    assign m_axis.tdata  = mem_q[rd_q][DATA_W-1:0];

    // Saturating frame counters and sticky error flags; a clear overrides updates.
    always_ff @(posedge aclk) begin
        if (!aresetn || clear_status) begin
            passed_q  <= 32'd0;
            dropped_q <= 32'd0;
            err_q     <= 3'd0;
        end else begin
            if (pass_inc) begin
                passed_q <= sat_add(passed_q, 2'd1);
            end
            if (drop_inc != 2'd0) begin
                dropped_q <= sat_add(dropped_q, drop_inc);
            end
            err_q <= err_q | err_set;
        end
    end

    assign status_frames_passed  = passed_q;
    assign status_frames_dropped = dropped_q;
    assign status_err            = err_q;
endmodule

// File: tb/tb_axis_video_frame_sync.sv
// Bench for axis_video_frame_sync: directed scenarios plus randomized frames,
// checked against a beat-index reference model of the frame rules.
module tb_axis_video_frame_sync;
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn, enable, clear_status;
    logic [15:0] cfg_l, cfg_r;
    logic [31:0] fp, fd;
    logic [2:0]  serr;

    axis_video_frame_sync_if s_if ();
    axis_video_frame_sync_if m_if ();

    axis_video_frame_sync dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .enable                (enable),
        .cfg_transfers_in_line (cfg_l),
        .cfg_lines_in_frame    (cfg_r),
        .clear_status          (clear_status),
        .s_axis                (s_if),
        .m_axis                (m_if),
        .status_frames_passed  (fp),
        .status_frames_dropped (fd),
        .status_err            (serr)
    );

    typedef struct packed {
        logic        u;
        logic        l;
        logic [5:0]  k;
        logic [47:0] d;
    } beat_t;

    beat_t       exp_q[$];
    logic [1:0]  stim_q[$];
    logic [31:0] m_pass, m_drop;
    logic [2:0]  m_err;
    bit          m_in;
    int          m_k, m_L, m_R;
    bit          rel;
    int          total = 0;
    int          passed = 0;
    int          out_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: a frame is L*R beats indexed by k; col = k % L.
    task automatic model_beat();
        bit    lastc;
        beat_t b;
        if (m_in && s_if.tuser && m_k != 0) begin
            m_err[2] = 1'b1;
            m_drop++;
            m_in = 0;
        end
        if (!m_in) begin
            if (!(s_if.tuser && enable && cfg_l != 16'd0 && cfg_r != 16'd0)) return;
            m_in = 1;
            m_k  = 0;
            m_L  = int'(cfg_l);
            m_R  = int'(cfg_r);
        end
        lastc = ((m_k % m_L) == m_L - 1);
        if (s_if.tlast && !lastc) begin
            m_err[0] = 1'b1;
            m_drop++;
            m_in = 0;
            return;
        end
        if (!s_if.tlast && lastc) begin
            m_err[1] = 1'b1;
            m_drop++;
            m_in = 0;
            return;
        end
        b.u = (m_k == 0);
        b.l = lastc;
        b.k = s_if.tkeep;
        b.d = s_if.tdata;
        exp_q.push_back(b);
        m_k++;
        if (m_k == m_L * m_R) begin
            m_pass++;
            m_in = 0;
        end
    endtask

    task automatic step(output bit acc);
        beat_t ob;
        @(negedge aclk);
        acc = 0;
        if (rel) begin
            chk("s_tready_occupancy", 64'(s_if.tready), 64'(exp_q.size() < 2));
            chk("m_tvalid_occupancy", 64'(m_if.tvalid), 64'(exp_q.size() != 0));
        end
        if (aresetn) begin
            acc = s_if.tvalid && s_if.tready;
            if (m_if.tvalid && m_if.tready && exp_q.size() != 0) begin
                ob = exp_q.pop_front();
                chk("out_beat", 64'({m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata}), 64'(ob));
                out_cnt++;
            end
            if (acc) model_beat();
            if (clear_status) begin
                m_pass = 0;
                m_drop = 0;
                m_err  = 0;
            end
        end else begin
            exp_q.delete();
            m_pass = 0;
            m_drop = 0;
            m_err  = 0;
            m_in   = 0;
        end
        @(posedge aclk);
        rel = aresetn;
        #1;
    endtask

    task automatic load(input logic [1:0] ul);
        s_if.tuser = ul[1];
        s_if.tlast = ul[0];
        s_if.tdata = 48'({$urandom, $urandom});
        s_if.tkeep = 6'($urandom);
    endtask

    task automatic add_beat(input logic u, input logic l);
        stim_q.push_back({u, l});
    endtask

    task automatic add_frame(input int L, input int R);
        logic u, l;
        for (int k = 0; k < L * R; k++) begin
            u = (k == 0);
            l = ((k % L) == L - 1);
            stim_q.push_back({u, l});
        end
    endtask

    task automatic play(input int stall, input bit bp, input int clear_at,
                        input bit jit, input bit en_drop, output int acc_stall);
        int          i, n, cyc;
        bit          acc;
        logic [15:0] sl, sr;
        i = 0;
        n = stim_q.size();
        cyc = 0;
        acc_stall = -1;
        sl = cfg_l;
        sr = cfg_r;
        if (n > 0) load(stim_q[0]);
        while (i < n && cyc < 40 * n + 100) begin
            s_if.tvalid = 1'b1;
            m_if.tready = (cyc < stall) ? 1'b0 : ((bp && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1);
            clear_status = (i == clear_at);
            if (cyc == stall) acc_stall = i;
            step(acc);
            cyc++;
            clear_status = 1'b0;
            if (acc) begin
                if (i == 0 && jit) begin
                    cfg_l = 16'($urandom_range(0, 6));
                    cfg_r = 16'($urandom_range(0, 3));
                end
                if (i == 0 && en_drop) enable = 1'b0;
                i++;
                if (i < n) load(stim_q[i]);
            end
        end
        s_if.tvalid = 1'b0;
        if (i < n) chk("play_timeout", 64'(i), 64'(n));
        cfg_l = sl;
        cfg_r = sr;
        stim_q.delete();
    endtask

    task automatic drain();
        bit acc;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        for (int i = 0; i < 6; i++) step(acc);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("frames_passed", 64'(fp), 64'(m_pass));
        chk("frames_dropped", 64'(fd), 64'(m_drop));
        chk("status_err", 64'(serr), 64'(m_err));
    endtask

    task automatic pulse_clear();
        bit acc;
        clear_status = 1'b1;
        step(acc);
        clear_status = 1'b0;
        chk("clear_passed", 64'(fp), 64'd0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tuser", 64'(m_if.tuser), 64'd0);
        chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
        chk("rst_m_tdata", 64'(m_if.tdata), 64'd0);
        chk("rst_m_tkeep", 64'(m_if.tkeep), 64'd0);
        chk("rst_passed", 64'(fp), 64'd0);
        chk("rst_dropped", 64'(fd), 64'd0);
        chk("rst_err", 64'(serr), 64'd0);
    endtask

    initial begin
        bit acc;
        int a2, oc;
        aresetn = 1'b0; enable = 1'b1; clear_status = 1'b0;
        cfg_l = 16'd4; cfg_r = 16'd2;
        s_if.tvalid = 1'b1; s_if.tuser = 1'b1; s_if.tlast = 1'b0;
        s_if.tdata = '0; s_if.tkeep = '0; m_if.tready = 1'b1;
        m_pass = 0; m_drop = 0; m_err = 0; m_in = 0; m_k = 0; m_L = 1; m_R = 1;
        rel = 0;

        // Reset state and release.
        repeat (3) step(acc);
        chk_reset_vals();
        s_if.tvalid = 1'b0;
        aresetn = 1'b1;
        step(acc);
        chk("tready_after_reset", 64'(s_if.tready), 64'd1);

        // One well-formed 4x2 frame.
        oc = out_cnt;
        add_frame(4, 2);
        play(0, 0, -1, 0, 0, a2);
        drain();
        chk("A_out_beats", 64'(out_cnt - oc), 64'd8);
        chk("A_passed", 64'(fp), 64'd1);
        chk("A_err", 64'(serr), 64'd0);

        // Joined mid-frame: 5 beats without SOF, then a full frame.
        pulse_clear();
        oc = out_cnt;
        for (int j = 0; j < 5; j++) add_beat(1'b0, (j == 3));
        add_frame(4, 2);
        play(0, 1, -1, 0, 0, a2);
        drain();
        chk("B_out_beats", 64'(out_cnt - oc), 64'd8);
        chk("B_passed", 64'(fp), 64'd1);

        // Early EOL at col 2, then recovery.
        pulse_clear();
        oc = out_cnt;
        add_beat(1'b1, 1'b0); add_beat(1'b0, 1'b0); add_beat(1'b0, 1'b1);
        play(0, 0, -1, 0, 0, a2);
        drain();
        chk("C_out_beats", 64'(out_cnt - oc), 64'd2);
        chk("C_err", 64'(serr), 64'd1);
        chk("C_dropped", 64'(fd), 64'd1);
        oc = out_cnt;
        add_beat(1'b0, 1'b0); add_beat(1'b0, 1'b1);
        add_frame(4, 2);
        play(0, 0, -1, 0, 0, a2);
        drain();
        chk("C_recover_beats", 64'(out_cnt - oc), 64'd8);
        chk("C_recover_passed", 64'(fp), 64'd1);

        // Downstream stall for 10 cycles with the source held valid.
        pulse_clear();
        oc = out_cnt;
        add_frame(4, 2);
        play(10, 0, -1, 0, 0, a2);
        chk("D_accepted_in_stall", 64'(a2), 64'd2);
        drain();
        chk("D_out_beats", 64'(out_cnt - oc), 64'd8);
        chk("D_passed", 64'(fp), 64'd1);

        // Unexpected SOF at col 1 relocks the frame.
        pulse_clear();
        oc = out_cnt;
        add_beat(1'b1, 1'b0); add_beat(1'b1, 1'b0);
        add_beat(1'b0, 1'b0); add_beat(1'b0, 1'b0); add_beat(1'b0, 1'b1);
        add_beat(1'b0, 1'b0); add_beat(1'b0, 1'b0); add_beat(1'b0, 1'b0); add_beat(1'b0, 1'b1);
        play(0, 0, -1, 0, 0, a2);
        drain();
        chk("E_out_beats", 64'(out_cnt - oc), 64'd9);
        chk("E_err", 64'(serr), 64'd4);
        chk("E_dropped", 64'(fd), 64'd1);
        chk("E_passed", 64'(fp), 64'd1);

        // Reset mid-frame with beats buffered.
        pulse_clear();
        add_frame(4, 2);
        play(0, 0, -1, 0, 0, a2);
        add_beat(1'b1, 1'b0); add_beat(1'b0, 1'b0);
        play(100, 0, -1, 0, 0, a2);
        aresetn = 1'b0;
        step(acc);
        chk_reset_vals();
        aresetn = 1'b1;
        step(acc);
        chk("F_tready_after_reset", 64'(s_if.tready), 64'd1);
        drain();

        // Clear coinciding with the final beat of a frame.
        add_frame(4, 2);
        play(0, 0, 7, 0, 0, a2);
        drain();
        chk("F_clear_wins", 64'(fp), 64'd0);

        // Randomized geometry, errors, backpressure, enable and cfg changes.
        for (int it = 0; it < 30; it++) begin
            int L, R;
            logic [1:0] t;
            L = $urandom_range(1, 5);
            R = $urandom_range(1, 3);
            cfg_l = 16'(L);
            cfg_r = 16'(R);
            if ($urandom_range(0, 9) == 0) cfg_l = 16'd0;
            enable = ($urandom_range(0, 7) != 0);
            repeat ($urandom_range(0, 2)) add_beat(1'b0, 1'($urandom_range(0, 1)));
            add_frame(L, R);
            for (int j = 0; j < stim_q.size(); j++) begin
                t = stim_q[j];
                if ($urandom_range(0, 14) == 0) t[0] = ~t[0];
                if ($urandom_range(0, 19) == 0) t[1] = 1'b1;
                stim_q[j] = t;
            end
            play(($urandom_range(0, 1) == 0) ? 0 : 5, 1,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), a2);
            enable = 1'b1;
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
